rename_regfile: RTL and testbench

RENAME_REGFILE -- requirements
Module: rename_regfile

---
 rtl/rename_regfile_pkg.sv | 28 ++
 rtl/rename_ckpt_bank.sv | 28 ++
 rtl/rename_regfile.sv | 92 +++++++++
 tb/tb_rename_regfile.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rename_regfile_pkg.sv
// rtl/rename_regfile_pkg.sv - shared widths, sentinels and tag-table helpers for the rename register file
package rename_regfile_pkg;

    localparam int REGNUM       = 32;
    localparam int BRNUM        = 4;
    localparam int TagBus       = 5;
    localparam int DataBus      = 32;
    localparam int RegAddrBus   = 5;
    localparam int BranchTagBus = 2;

    localparam logic [TagBus-1:0]  tagFree  = 5'b10000;
    localparam logic [DataBus-1:0] dataFree = 32'h0;

    typedef logic [REGNUM-1:0][TagBus-1:0] tag_table_t;

    // A committing ROB tag no longer names a pending producer anywhere in a table.
    function automatic tag_table_t commit_clear(input tag_table_t tbl,
                                                input logic en,
                                                input logic [TagBus-1:0] ctag);
        tag_table_t r;
        r = tbl;
        for (int i = 0; i < REGNUM; i++) begin
            if (en && (tbl[i] == ctag)) r[i] = tagFree;
        end
        return r;
    endfunction

endpackage

// File: rtl/rename_ckpt_bank.sv
// rtl/rename_ckpt_bank.sv - one branch checkpoint slot: capture, commit clear, readout
module rename_ckpt_bank
    import rename_regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cap_en_i,
    input  tag_table_t        cap_tbl_i,
    input  logic              clr_en_i,
    input  logic [TagBus-1:0] clr_tag_i,
    output tag_table_t        tbl_o
);

    tag_table_t tbl_q, tbl_d;

    always_comb begin
        tbl_d = commit_clear(tbl_q, clr_en_i, clr_tag_i);
        if (cap_en_i) tbl_d = cap_tbl_i;
    end

    always_ff @(posedge clk) begin
        if (rst) tbl_q <= {REGNUM{tagFree}};
        else     tbl_q <= tbl_d;
    end

    assign tbl_o = tbl_q;

endmodule

// File: rtl/rename_regfile.sv
// rtl/rename_regfile.sv - renamed architectural register file with commit bypass and branch checkpoints
module rename_regfile
    import rename_regfile_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enCom,
    input  logic [TagBus-1:0]       ComTag,
    input  logic [RegAddrBus-1:0]   ComAddr,
    input  logic [DataBus-1:0]      ComData,
    input  logic [RegAddrBus-1:0]   ReadAddrO,
    input  logic [RegAddrBus-1:0]   ReadAddrT,
    output logic [TagBus-1:0]       ReadTagO,
    output logic [TagBus-1:0]       ReadTagT,
    output logic [DataBus-1:0]      ReadDataO,
    output logic [DataBus-1:0]      ReadDataT,
    input  logic                    dispEn,
    input  logic [RegAddrBus-1:0]   dispRd,
    input  logic [TagBus-1:0]       dispTag,
    input  logic                    bCheckEn,
    input  logic [BranchTagBus-1:0] bCheckNum,
    input  logic                    bFreeEn,
    input  logic [BranchTagBus-1:0] bFreeNum,
    input  logic                    misTaken,
    output logic [BRNUM-1:0]        ckptValid
);

    tag_table_t         tag_q, tag_d;
    tag_table_t         ck_tbl [BRNUM];
    logic [DataBus-1:0] data_q [REGNUM];
    logic [BRNUM-1:0]   valid_q, valid_d;
    logic               mis;

    assign mis       = bFreeEn & misTaken;
    assign ckptValid = valid_q;

    for (genvar s = 0; s < BRNUM; s++) begin : g_ckpt
        rename_ckpt_bank u_bank (
            .clk       (clk),
            .rst       (rst),
            .cap_en_i  (bCheckEn && !mis && (bCheckNum == BranchTagBus'(s))),
            .cap_tbl_i (tag_d),
            .clr_en_i  (enCom),
            .clr_tag_i (ComTag),
            .tbl_o     (ck_tbl[s])
        );
    end

    // Next tag table doubles as the checkpoint capture value, so it includes this cycle's dispatch.
    always_comb begin
        if (mis) begin
            tag_d = commit_clear(ck_tbl[bFreeNum], enCom, ComTag);
        end else begin
            tag_d = commit_clear(tag_q, enCom, ComTag);
            if (dispEn && (dispRd != '0)) tag_d[dispRd] = dispTag;
        end
        tag_d[0] = tagFree;
    end

    always_comb begin
        valid_d = valid_q;
        if (mis) begin
            valid_d = '0;
        end else begin
            if (bFreeEn)  valid_d[bFreeNum]  = 1'b0;
            if (bCheckEn) valid_d[bCheckNum] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q   <= {REGNUM{tagFree}};
            valid_q <= '0;
            for (int i = 0; i < REGNUM; i++) data_q[i] <= '0;
        end else begin
            tag_q   <= tag_d;
            valid_q <= valid_d;
            if (enCom && (ComAddr != '0)) data_q[ComAddr] <= ComData;
        end
    end

    function automatic logic [TagBus+DataBus-1:0] read_reg(input logic [RegAddrBus-1:0] a);
        if (a == '0)                        return {tagFree, dataFree};
        else if (enCom && tag_q[a] == ComTag) return {tagFree, ComData};
        else if (tag_q[a] != tagFree)       return {tag_q[a], dataFree};
        else                                return {tagFree, data_q[a]};
    endfunction

    always_comb {ReadTagO, ReadDataO} = read_reg(ReadAddrO);
    always_comb {ReadTagT, ReadDataT} = read_reg(ReadAddrT);

endmodule

// File: tb/tb_rename_regfile.sv
// tb/tb_rename_regfile.sv - directed self-checking bench for rename_regfile with a per-cycle reference model
module tb_rename_regfile;

    localparam logic [4:0] TF = 5'b10000;

    logic        clk = 1'b0;
    logic        rst, enCom, dispEn, bCheckEn, bFreeEn, misTaken;
    logic [4:0]  ComTag, ComAddr, ReadAddrO, ReadAddrT, dispRd, dispTag;
    logic [31:0] ComData;
    logic [1:0]  bCheckNum, bFreeNum;
    logic [4:0]  ReadTagO, ReadTagT;
    logic [31:0] ReadDataO, ReadDataT;
    logic [3:0]  ckptValid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_data [32];
    logic [4:0]  m_tag  [32];
    logic [4:0]  m_ck   [4][32];
    logic [3:0]  m_valid;
    bit          m_live = 0;

    always #5 clk = ~clk;

    rename_regfile dut (
        .clk(clk), .rst(rst), .enCom(enCom), .ComTag(ComTag), .ComAddr(ComAddr), .ComData(ComData),
        .ReadAddrO(ReadAddrO), .ReadAddrT(ReadAddrT), .ReadTagO(ReadTagO), .ReadTagT(ReadTagT),
        .ReadDataO(ReadDataO), .ReadDataT(ReadDataT), .dispEn(dispEn), .dispRd(dispRd), .dispTag(dispTag),
        .bCheckEn(bCheckEn), .bCheckNum(bCheckNum), .bFreeEn(bFreeEn), .bFreeNum(bFreeNum),
        .misTaken(misTaken), .ckptValid(ckptValid)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [36:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return {TF, 32'h0};
        if (enCom && m_tag[a] == ComTag) return {TF, ComData};
        if (m_tag[a] != TF) return {m_tag[a], 32'h0};
        return {TF, m_data[a]};
    endfunction

    task automatic model_update();
        logic [4:0] nt [32];
        bit mis;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_data[i] = 32'h0;
                m_tag[i]  = TF;
                for (int s = 0; s < 4; s++) m_ck[s][i] = TF;
            end
            m_valid = 4'h0;
            m_live  = 1;
            return;
        end
        mis = bFreeEn && misTaken;
        for (int i = 0; i < 32; i++) begin
            nt[i] = mis ? m_ck[bFreeNum][i] : m_tag[i];
            if (enCom && nt[i] == ComTag) nt[i] = TF;
        end
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < 32; i++)
                if (enCom && m_ck[s][i] == ComTag) m_ck[s][i] = TF;
        if (!mis && dispEn && dispRd != 5'd0) nt[dispRd] = dispTag;
        nt[0] = TF;
        if (enCom && ComAddr != 5'd0) m_data[ComAddr] = ComData;
        if (mis) m_valid = 4'h0;
        else begin
            if (bFreeEn) m_valid[bFreeNum] = 1'b0;
            if (bCheckEn) begin
                m_valid[bCheckNum] = 1'b1;
                for (int i = 0; i < 32; i++) m_ck[bCheckNum][i] = nt[i];
            end
        end
        for (int i = 0; i < 32; i++) m_tag[i] = nt[i];
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            logic [36:0] eo, et;
            eo = m_read(ReadAddrO);
            et = m_read(ReadAddrT);
            check("model tagO",  {27'h0, ReadTagO}, {27'h0, eo[36:32]});
            check("model dataO", ReadDataO, eo[31:0]);
            check("model tagT",  {27'h0, ReadTagT}, {27'h0, et[36:32]});
            check("model dataT", ReadDataT, et[31:0]);
            check("model valid", {28'h0, ckptValid}, {28'h0, m_valid});
        end
    end

    task automatic set_idle();
        rst = 0; enCom = 0; ComTag = 0; ComAddr = 0; ComData = 0;
        dispEn = 0; dispRd = 0; dispTag = 0;
        bCheckEn = 0; bCheckNum = 0; bFreeEn = 0; bFreeNum = 0; misTaken = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #2;
        set_idle();
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic disp(input logic [4:0] rd, input logic [4:0] t);
        dispEn = 1; dispRd = rd; dispTag = t;
    endtask

    task automatic commit(input logic [4:0] t, input logic [4:0] a, input logic [31:0] d);
        enCom = 1; ComTag = t; ComAddr = a; ComData = d;
    endtask

    task automatic rd_chk(input string nm, input logic [4:0] et, input logic [31:0] ed);
        check({nm, " tag"},  {27'h0, ReadTagO}, {27'h0, et});
        check({nm, " data"}, ReadDataO, ed);
    endtask

    initial begin
        set_idle();
        ReadAddrO = 0; ReadAddrT = 0;
        rst = 1;
        tick();
        ReadAddrO = 5; settle();
        rd_chk("reset x5", TF, 32'h0);
        check("reset valid", {28'h0, ckptValid}, 32'h0);

        disp(5, 3); tick();
        ReadAddrO = 5; settle();
        rd_chk("x5 pending", 5'd3, 32'h0);
        commit(3, 5, 32'hAB); settle();
        rd_chk("x5 bypass", TF, 32'hAB);
        tick();
        settle();
        rd_chk("x5 committed", TF, 32'hAB);

        disp(7, 4); tick();
        disp(7, 6); tick();
        commit(4, 7, 32'h1234); tick();
        ReadAddrO = 7; settle();
        rd_chk("x7 younger tag kept", 5'd6, 32'h0);
        commit(6, 7, 32'h66); tick();
        settle();
        rd_chk("x7 final", TF, 32'h66);

        disp(1, 2); bCheckEn = 1; bCheckNum = 1; tick();
        ReadAddrO = 1; settle();
        check("ckpt1 valid", {28'h0, ckptValid}, 32'h2);
        disp(1, 9); tick();
        settle();
        rd_chk("x1 renamed", 5'd9, 32'h0);
        bFreeEn = 1; bFreeNum = 1; misTaken = 1; tick();
        settle();
        rd_chk("x1 restored", 5'd2, 32'h0);
        check("valid after mispredict", {28'h0, ckptValid}, 32'h0);

        disp(3, 5); bCheckEn = 1; bCheckNum = 0; tick();
        commit(5, 3, 32'h55); tick();
        ReadAddrO = 3; settle();
        rd_chk("x3 committed", TF, 32'h55);
        bFreeEn = 1; bFreeNum = 0; misTaken = 1; tick();
        ReadAddrT = 1; settle();
        rd_chk("x3 restore cleared", TF, 32'h55);
        check("x1 restore slot0", {27'h0, ReadTagT}, {27'h0, 5'd2});

        disp(4, 8); bCheckEn = 1; bCheckNum = 1; tick();
        bFreeEn = 1; bFreeNum = 1; misTaken = 1; commit(8, 4, 32'h44);
        disp(6, 12); bCheckEn = 1; bCheckNum = 2; tick();
        ReadAddrO = 4; ReadAddrT = 6; settle();
        rd_chk("x4 clear during restore", TF, 32'h44);
        check("x6 dispatch dropped", {27'h0, ReadTagT}, {27'h0, TF});
        check("ckpt dropped", {28'h0, ckptValid}, 32'h0);

        bCheckEn = 1; bCheckNum = 2; bFreeEn = 1; bFreeNum = 2; tick();
        settle();
        check("ckpt beats free", {28'h0, ckptValid}, 32'h4);
        bCheckEn = 1; bCheckNum = 3; tick();
        bFreeEn = 1; bFreeNum = 2; tick();
        settle();
        check("correct resolve", {28'h0, ckptValid}, 32'h8);

        disp(0, 1); commit(7, 0, 32'hFF); ReadAddrO = 0; ReadAddrT = 0; tick();
        settle();
        rd_chk("x0 fixed", TF, 32'h0);

        disp(9, 11); bCheckEn = 1; bCheckNum = 0; tick();
        ReadAddrO = 9; ReadAddrT = 5; settle();
        rd_chk("x9 pending", 5'd11, 32'h0);
        rst = 1; disp(10, 13); commit(2, 1, 32'h99); tick();
        settle();
        rd_chk("x9 after reset", TF, 32'h0);
        check("x5 data after reset", ReadDataT, 32'h0);
        check("valid after reset", {28'h0, ckptValid}, 32'h0);
        ReadAddrO = 10; ReadAddrT = 1; settle();
        rd_chk("x10 reset wins", TF, 32'h0);
        check("x1 reset data", ReadDataT, 32'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
